// File: rtl/gsr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  gsr_ctrl_pkg
//  Shared state encoding and constants for the GSR pulse sequencer.
//  Revision: 1.0
// ============================================================================
package gsr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ASSERT   = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_WAIT_EOS = 3'd3,
        ST_ACK      = 3'd4
    } gsr_state_t;

    localparam int          C_CNT_W_DEF       = 16;
    localparam logic [15:0] C_TIMEOUT_MAX     = 16'hFFFF;
    localparam logic [15:0] C_DEF_PULSE_LEN   = 16'd16;
    localparam logic [15:0] C_DEF_SETTLE_LEN  = 16'd64;

endpackage : gsr_ctrl_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  rr_arbiter
//  Combinational round-robin pick: first set request at or after ptr.
//  Revision: 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] grant,
    output logic [2:0]      grant_idx,
    output logic            any
);

    logic [NREQ-1:0] w_rot;
    logic [3:0]      w_sum;

    always_comb begin
        w_rot     = NREQ'({req, req} >> ptr);
        w_sum     = 4'd0;
        grant     = '0;
        grant_idx = 3'd0;
        any       = 1'b0;
        // Descending scan so the smallest offset from ptr is the last writer
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                any   = 1'b1;
                w_sum = {1'b0, ptr} + 4'(i);
                if (w_sum >= 4'(NREQ)) begin
                    w_sum = w_sum - 4'(NREQ);
                end
                grant_idx = w_sum[2:0];
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (any && (grant_idx == 3'(j))) begin
                grant[j] = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/gsr_pulse_ctrl.sv
`default_nettype none
// ============================================================================
//  gsr_pulse_ctrl
//  Arbitrates GSR requests and sequences one pulse/settle/EOS cycle per grant.
//  Revision: 1.0
// ============================================================================
module gsr_pulse_ctrl
    import gsr_ctrl_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             plrest,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  ack,
    input  logic [CNT_W-1:0] pulse_len,
    input  logic [CNT_W-1:0] settle_len,
    input  logic             eos_in,
    output logic             gsr_out,
    output logic             busy,
    output logic [2:0]       grant_id,
    output logic [31:0]      pulse_count,
    output logic             err_timeout
);

    gsr_state_t       r_state;
    gsr_state_t       w_next;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_settle_q;
    logic [CNT_W-1:0] r_tcnt;
    logic [2:0]       r_rr_ptr;
    logic [2:0]       r_grant_id;
    logic [NREQ-1:0]  r_grant_oh;
    logic [NREQ-1:0]  r_ack;
    logic             r_gsr;
    logic [31:0]      r_pulse_count;
    logic             r_err;

    logic [NREQ-1:0]  w_grant_oh;
    logic [2:0]       w_grant_idx;
    logic             w_any;
    logic [2:0]       w_ptr_next;
    logic             w_tmo;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req       (req),
        .ptr       (r_rr_ptr),
        .grant     (w_grant_oh),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    assign w_ptr_next = (w_grant_idx == 3'(NREQ - 1)) ? 3'd0 : w_grant_idx + 3'd1;
    assign w_tmo      = (r_tcnt == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (plrest) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_any) w_next = ST_ASSERT;
            ST_ASSERT:   if (r_cnt <= CNT_W'(1)) w_next = ST_SETTLE;
            ST_SETTLE:   if (r_cnt == '0) w_next = ST_WAIT_EOS;
            ST_WAIT_EOS: if (eos_in || w_tmo) w_next = ST_ACK;
            ST_ACK:      w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (plrest) begin
            r_cnt         <= '0;
            r_settle_q    <= '0;
            r_tcnt        <= '0;
            r_rr_ptr      <= 3'd0;
            r_grant_id    <= 3'd0;
            r_grant_oh    <= '0;
            r_ack         <= '0;
            r_gsr         <= 1'b0;
            r_pulse_count <= 32'd0;
            r_err         <= 1'b0;
        end else begin
            // Outputs registered from next state so they align with the state
            r_gsr <= (w_next == ST_ASSERT);
            r_ack <= (w_next == ST_ACK) ? r_grant_oh : '0;
            case (r_state)
                ST_IDLE: begin
                    r_tcnt <= '0;
                    if (w_any) begin
                        r_grant_id <= w_grant_idx;
                        r_grant_oh <= w_grant_oh;
                        r_cnt      <= (pulse_len == '0) ? CNT_W'(1) : pulse_len;
                        r_settle_q <= settle_len;
                        r_rr_ptr   <= w_ptr_next;
                    end
                end
                ST_ASSERT: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        r_cnt <= r_settle_q;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    r_tcnt <= '0;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_WAIT_EOS: begin
                    if (!eos_in) begin
                        if (w_tmo) begin
                            r_err <= 1'b1;
                        end else begin
                            r_tcnt <= r_tcnt + CNT_W'(1);
                        end
                    end
                end
                ST_ACK: begin
                    r_pulse_count <= r_pulse_count + 32'd1;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign gsr_out     = r_gsr;
    assign ack         = r_ack;
    assign busy        = (r_state != ST_IDLE);
    assign grant_id    = r_grant_id;
    assign pulse_count = r_pulse_count;
    assign err_timeout = r_err;

endmodule : gsr_pulse_ctrl
`default_nettype wire

// File: tb/tb_gsr_pulse_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_gsr_pulse_ctrl
//  Randomised scoreboard bench for the GSR pulse sequencer.
//  Revision: 1.0
// ============================================================================
module tb_gsr_pulse_ctrl;

    localparam int NREQ  = 3;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             plrest = 1'b1;
    logic [NREQ-1:0]  req = '0;
    logic [NREQ-1:0]  ack;
    logic [CNT_W-1:0] pulse_len = '0;
    logic [CNT_W-1:0] settle_len = '0;
    logic             eos_in = 1'b1;
    logic             gsr_out;
    logic             busy;
    logic [2:0]       grant_id;
    logic [31:0]      pulse_count;
    logic             err_timeout;

    gsr_pulse_ctrl #(
        .NREQ  (NREQ),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .plrest      (plrest),
        .req         (req),
        .ack         (ack),
        .pulse_len   (pulse_len),
        .settle_len  (settle_len),
        .eos_in      (eos_in),
        .gsr_out     (gsr_out),
        .busy        (busy),
        .grant_id    (grant_id),
        .pulse_count (pulse_count),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NREQ-1:0] ack_mask;
        int              gid;
        int              ack_e;
        int              tol;
        int              width;
        int              rise_e;
        logic            err;
        int              count;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   m_ptr = 0;
    int   m_count = 0;
    logic m_err = 1'b0;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Reference rule: first requester at or after the pointer, cyclically
    function automatic int winner(input logic [NREQ-1:0] m, input int ptr);
        int mi;
        int idx;
        mi = int'(m);
        for (int k = 0; k < NREQ; k++) begin
            idx = (ptr + k) % NREQ;
            if (((mi >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    // Monitor: tracks the GSR pulse shape and scores every acknowledge
    initial begin : monitor
        int   rise_e;
        int   width;
        logic prev;
        exp_t e;
        rise_e = 0;
        width  = 0;
        prev   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (plrest) begin
                prev  = 1'b0;
                width = 0;
            end else begin
                if (gsr_out && !prev) begin
                    rise_e = cyc;
                    width  = 1;
                end else if (gsr_out) begin
                    width++;
                end
                prev = gsr_out;
                if (ack != '0) begin
                    if (q.size() == 0) begin
                        check("unexpected_ack", longint'(ack), 0);
                    end else begin
                        e = q.pop_front();
                        check("ack_mask", longint'(ack), longint'(e.ack_mask));
                        check("grant_id", longint'(grant_id), e.gid);
                        checks++;
                        if (cyc < e.ack_e - e.tol || cyc > e.ack_e + e.tol) begin
                            errors++;
                            $display("FAIL ack_cycle: got %0d, expected %0d (+/-%0d)", cyc, e.ack_e, e.tol);
                        end
                        check("gsr_width", width, e.width);
                        check("gsr_rise_cycle", rise_e, e.rise_e);
                        check("err_timeout", longint'(err_timeout), longint'(e.err));
                        check("pulse_count_at_ack", longint'(pulse_count), e.count);
                        check("busy_at_ack", longint'(busy), 1);
                    end
                end
            end
        end
    end

    // Serve every master in mask; caller is at a negedge with the DUT idle.
    // mode 0: EOS high, 1: EOS rises after a random delay, 2: EOS never returns
    task automatic serve(input logic [NREQ-1:0] mask, input int pfix, input int sfix, input int mode);
        logic [NREQ-1:0] pend;
        int   p, st, pw, s, w, base, rise, ack_e;
        exp_t e;
        pend = mask;
        req  = mask;
        while (pend != '0) begin
            p  = (pfix < 0) ? int'($urandom_range(0, 12)) : pfix;
            st = (sfix < 0) ? int'($urandom_range(0, 10)) : sfix;
            pulse_len  = CNT_W'(p);
            settle_len = CNT_W'(st);
            s    = cyc + 1;
            w    = winner(pend, m_ptr);
            pw   = (p == 0) ? 1 : p;
            base = s + pw + st + 2;
            rise = -1;
            e.tol = 0;
            case (mode)
                0: begin
                    eos_in = 1'b1;
                    ack_e  = base;
                end
                1: begin
                    eos_in = 1'b0;
                    rise   = s + int'($urandom_range(0, 40));
                    ack_e  = (rise + 1 > base) ? rise + 1 : base;
                end
                default: begin
                    eos_in = 1'b0;
                    ack_e  = base + 65535;
                    e.tol  = 1;
                    m_err  = 1'b1;
                end
            endcase
            e.ack_mask = NREQ'(1 << w);
            e.gid      = w;
            e.ack_e    = ack_e;
            e.width    = pw;
            e.rise_e   = s;
            e.err      = m_err;
            e.count    = m_count;
            q.push_back(e);
            m_ptr   = (w + 1) % NREQ;
            m_count = m_count + 1;
            @(negedge clk);
            // Lengths must be ignored once the grant has been taken
            pulse_len  = CNT_W'($urandom_range(13, 40));
            settle_len = CNT_W'($urandom_range(13, 40));
            forever begin
                if (cyc == rise) eos_in = 1'b1;
                if (ack != '0) break;
                if (cyc > ack_e + e.tol + 8) begin
                    errors++;
                    checks++;
                    $display("FAIL ack_wait: no ack by cycle %0d, expected %0d", cyc, ack_e);
                    finish_run();
                    return;
                end
                @(negedge clk);
            end
            pend   = pend & ~NREQ'(1 << w);
            req    = req & ~NREQ'(1 << w);
            eos_in = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_gsr"}, longint'(gsr_out), 0);
        check({tag, "_ack"}, longint'(ack), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_grant_id"}, longint'(grant_id), 0);
        check({tag, "_pulse_count"}, longint'(pulse_count), 0);
        check({tag, "_err"}, longint'(err_timeout), 0);
    endtask

    task automatic apply_reset(input string tag);
        plrest = 1'b1;
        req    = '0;
        @(posedge clk);
        #1;
        check_reset_state(tag);
        @(negedge clk);
        plrest  = 1'b0;
        m_ptr   = 0;
        m_count = 0;
        m_err   = 1'b0;
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        repeat (3) @(negedge clk);
        apply_reset("reset");

        serve(NREQ'(1), 4, 2, 0);
        check("pulse_count_1", longint'(pulse_count), 1);

        serve(NREQ'(3), -1, -1, 0);
        serve(NREQ'(3), -1, -1, 0);
        serve(NREQ'(1), 0, 0, 0);
        serve(NREQ'(1), 5, 3, 0);
        serve(NREQ'(7), -1, -1, 0);

        // Reset in the second ASSERT cycle of an 8-cycle pulse
        req        = NREQ'(2);
        pulse_len  = CNT_W'(8);
        settle_len = CNT_W'(3);
        eos_in     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("gsr_before_reset", longint'(gsr_out), 1);
        apply_reset("mid_reset");
        repeat (20) @(negedge clk);
        check("no_ack_after_reset", longint'(q.size()), 0);
        check("count_after_reset", longint'(pulse_count), 0);

        serve(NREQ'(7), -1, -1, 0);

        for (int it = 0; it < 40; it++) begin
            serve(NREQ'($urandom_range(1, (1 << NREQ) - 1)),
                  -1, -1, ($urandom_range(0, 3) == 0) ? 1 : 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        serve(NREQ'(1), 2, 1, 2);
        serve(NREQ'(2), -1, -1, 0);
        check("err_sticky", longint'(err_timeout), 1);
        apply_reset("err_clear");

        repeat (3) @(negedge clk);
        check("queue_empty", longint'(q.size()), 0);
        check("final_pulse_count", longint'(pulse_count), m_count);
        finish_run();
    end

endmodule : tb_gsr_pulse_ctrl
`default_nettype wire
